// File: rtl/redirect_ctrl_pkg.sv
// Shared command encodings, per-port FSM states and the table-update payload
// for the error-redirect controller.
package ariane_soc;
  localparam logic [63:0] ERROR_REDIRECT      = 64'hEEEE_0000_0000_0001;
  localparam logic [63:0] ERROR_REDIRECT_STOP = 64'hEEEE_0000_0000_0002;
endpackage

package redirect_ctrl_pkg;
  localparam int unsigned UPD_N_PORT = 7;
  localparam int unsigned UPD_PORT_W = $clog2(UPD_N_PORT);
  localparam int unsigned UPD_INIT_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    PEND_ON  = 3'd2,
    ACTIVE   = 3'd3,
    PEND_OFF = 3'd4
  } redirect_state_e;

  typedef struct packed {
    logic [UPD_PORT_W-1:0] port;
    logic                  install;
    logic [UPD_INIT_W-1:0] source;
    logic [UPD_INIT_W-1:0] target;
  } redirect_upd_t;
endpackage

// File: rtl/redirect_ctrl_rr_arbiter.sv
// Round-robin arbiter with a registered winner payload held until accepted.
module redirect_rr_arbiter #(
  parameter int unsigned N      = 7,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N-1:0]               req_i,
  input  logic [N-1:0][DATA_W-1:0]   data_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          data_o
);
  localparam int unsigned IDX_W = $clog2(N);

  logic              valid_q;
  logic [IDX_W-1:0]  idx_q, ptr_q, start, win;
  logic [DATA_W-1:0] data_q;
  logic              hs, load, found;
  logic [N-1:0]      cand;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(N-1)) ? '0 : x + 1'b1;
  endfunction

  // On a handshake the accepted port still shows its request this cycle, so
  // it is masked out and the search starts just past it.
  always_comb begin
    int unsigned p;
    p     = 0;
    hs    = valid_q & ready_i;
    load  = ~valid_q | ready_i;
    start = hs ? wrap_inc(idx_q) : ptr_q;
    cand  = req_i;
    if (hs) cand[idx_q] = 1'b0;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      p = (32'(start) + k) % N;
      if (!found && cand[p]) begin
        found = 1'b1;
        win   = IDX_W'(p);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      if (load) begin
        valid_q <= found;
        if (found) begin
          idx_q  <= win;
          data_q <= data_i[win];
        end
      end
      if (hs) ptr_q <= wrap_inc(idx_q);
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/redirect_ctrl.sv
// Per-port error-redirect command decoder with arm timeout, serialising
// install/remove requests onto one redirect-table update channel.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int unsigned N_TARG_PORT = 7,
  parameter int unsigned AXI_DATA_W  = 64,
  parameter int unsigned LOG_N_INIT  = 2,
  parameter int unsigned ARM_TIMEOUT = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]  wdata_i,
  input  logic [N_TARG_PORT-1:0]                  wvalid_i,
  input  logic [N_TARG_PORT-1:0]                  wready_i,
  output logic                                    upd_valid_o,
  input  logic                                    upd_ready_i,
  output logic [$clog2(N_TARG_PORT)-1:0]          upd_port_o,
  output logic                                    upd_install_o,
  output logic [LOG_N_INIT-1:0]                   upd_source_o,
  output logic [LOG_N_INIT-1:0]                   upd_target_o,
  output logic [N_TARG_PORT-1:0]                  redirect_valid_o,
  output logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0]  source_o,
  output logic [N_TARG_PORT-1:0][LOG_N_INIT-1:0]  target_o,
  output logic [N_TARG_PORT-1:0]                  proto_err_o
);
  localparam int unsigned PORT_W = $clog2(N_TARG_PORT);
  localparam int unsigned TMR_W  = $clog2(ARM_TIMEOUT);
  localparam int unsigned UPD_W  = $bits(redirect_upd_t);

  logic [N_TARG_PORT-1:0]            req;
  logic [N_TARG_PORT-1:0][UPD_W-1:0] payload;
  logic [UPD_W-1:0]                  upd_raw;
  redirect_upd_t                     upd;

  for (genvar i = 0; i < N_TARG_PORT; i++) begin : g_port
    redirect_state_e       state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [LOG_N_INIT-1:0] src_q, src_d, tgt_q, tgt_d;
    logic                  err_q, err_d;
    logic                  beat, is_cmd, is_stop, is_data, own, hs;
    redirect_upd_t         pl;

    assign beat    = wvalid_i[i] & wready_i[i];
    assign is_cmd  = beat & (wdata_i[i] == AXI_DATA_W'(ariane_soc::ERROR_REDIRECT));
    assign is_stop = beat & (wdata_i[i] == AXI_DATA_W'(ariane_soc::ERROR_REDIRECT_STOP));
    assign is_data = beat & ~is_cmd & ~is_stop;
    assign own     = upd_valid_o & (upd_port_o == PORT_W'(i));
    assign hs      = own & upd_ready_i;

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      src_d   = src_q;
      tgt_d   = tgt_q;
      err_d   = 1'b0;
      case (state_q)
        IDLE: if (is_cmd) begin
          state_d = ARMED;
          tmr_d   = '0;
        end
        ARMED: begin
          if (is_data) begin
            tgt_d   = wdata_i[i][32 +: LOG_N_INIT];
            src_d   = wdata_i[i][LOG_N_INIT-1:0];
            state_d = PEND_ON;
          end else if (is_stop) begin
            state_d = IDLE;
          end else if (is_cmd) begin
            tmr_d = '0;
          end else if (tmr_q == TMR_W'(ARM_TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        // A STOP after the install is already registered cannot be withdrawn;
        // PEND_OFF then sees that install accepted before queuing the remove.
        PEND_ON: begin
          if (hs)           state_d = is_stop ? PEND_OFF : ACTIVE;
          else if (is_stop) state_d = own ? PEND_OFF : IDLE;
        end
        ACTIVE: begin
          if (is_stop)     state_d = PEND_OFF;
          else if (is_cmd) err_d   = 1'b1;
        end
        PEND_OFF: if (hs && !upd.install) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        tmr_q   <= '0;
        src_q   <= '0;
        tgt_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
        src_q   <= src_d;
        tgt_q   <= tgt_d;
        err_q   <= err_d;
      end
    end

    // A same-cycle STOP withdraws a not-yet-registered install request.
    assign req[i]  = ((state_q == PEND_ON) & ~is_stop) | (state_q == PEND_OFF);
    assign pl      = '{port: UPD_PORT_W'(i), install: (state_q == PEND_ON),
                       source: src_q, target: tgt_q};
    assign payload[i] = pl;

    assign redirect_valid_o[i] = (state_q == ACTIVE) | (state_q == PEND_OFF);
    assign source_o[i]         = src_q;
    assign target_o[i]         = tgt_q;
    assign proto_err_o[i]      = err_q;
  end

  redirect_rr_arbiter #(
    .N      (N_TARG_PORT),
    .DATA_W (UPD_W)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req),
    .data_i  (payload),
    .ready_i (upd_ready_i),
    .valid_o (upd_valid_o),
    .data_o  (upd_raw)
  );

  assign upd           = redirect_upd_t'(upd_raw);
  assign upd_port_o    = upd.port;
  assign upd_install_o = upd.install;
  assign upd_source_o  = upd.source;
  assign upd_target_o  = upd.target;
endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl with hand-computed expectations.
module tb_redirect_ctrl;
  localparam int unsigned NP = 7;
  localparam int unsigned DW = 64;
  localparam int unsigned LI = 2;
  localparam logic [63:0] CMD  = ariane_soc::ERROR_REDIRECT;
  localparam logic [63:0] STOP = ariane_soc::ERROR_REDIRECT_STOP;

  logic                    clk;
  logic                    rst;
  logic [NP-1:0][DW-1:0]   wdata;
  logic [NP-1:0]           wvalid, wready;
  logic                    upd_valid, upd_ready, upd_install;
  logic [2:0]              upd_port;
  logic [LI-1:0]           upd_source, upd_target;
  logic [NP-1:0]           redirect_valid, proto_err;
  logic [NP-1:0][LI-1:0]   source, target;

  int vecs = 0;
  int errs = 0;

  redirect_ctrl #(
    .N_TARG_PORT (NP),
    .AXI_DATA_W  (DW),
    .LOG_N_INIT  (LI),
    .ARM_TIMEOUT (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .wdata_i          (wdata),
    .wvalid_i         (wvalid),
    .wready_i         (wready),
    .upd_valid_o      (upd_valid),
    .upd_ready_i      (upd_ready),
    .upd_port_o       (upd_port),
    .upd_install_o    (upd_install),
    .upd_source_o     (upd_source),
    .upd_target_o     (upd_target),
    .redirect_valid_o (redirect_valid),
    .source_o         (source),
    .target_o         (target),
    .proto_err_o      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [NP-1:0] m, input logic [63:0] d);
    for (int p = 0; p < NP; p++) begin
      if (m[p]) begin
        wdata[p]  = d;
        wvalid[p] = 1'b1;
        wready[p] = 1'b1;
      end
    end
    tick();
    wvalid = '0;
    wready = '0;
    wdata  = '0;
  endtask

  task automatic chk_upd(input string tag, input logic [2:0] port, input logic inst);
    chk({tag, "_valid"}, upd_valid, 1'b1);
    chk({tag, "_port"}, upd_port, port);
    chk({tag, "_install"}, upd_install, inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] exp_upd;
    rst = 1'b1; upd_ready = 1'b1;
    wvalid = '0; wready = '0; wdata = '0;
    tick(); tick();
    chk("rst_upd_valid", upd_valid, 1'b0);
    chk("rst_redirect", redirect_valid, '0);
    chk("rst_err", proto_err, '0);
    chk("rst_source", source, '0);
    rst = 1'b0;
    tick();

    // Basic install on port 2
    beat(7'b0000100, CMD);
    beat(7'b0000100, 64'h0000_0003_0000_0001);
    chk("pend_upd_valid", upd_valid, 1'b0);
    tick();
    chk_upd("inst2", 3'd2, 1'b1);
    chk("inst2_src", upd_source, 2'd1);
    chk("inst2_tgt", upd_target, 2'd3);
    chk("inst2_redir_early", redirect_valid, 7'b0000000);
    tick();
    chk("inst2_redir", redirect_valid, 7'b0000100);
    chk("inst2_upd_drop", upd_valid, 1'b0);
    chk("src2", source[2], 2'd1);
    chk("tgt2", target[2], 2'd3);

    // Remove on port 2
    beat(7'b0000100, STOP);
    chk("off2_redir_hold", redirect_valid, 7'b0000100);
    tick();
    chk_upd("rem2", 3'd2, 1'b0);
    chk("rem2_redir", redirect_valid, 7'b0000100);
    tick();
    chk("rem2_redir_clr", redirect_valid, 7'b0000000);
    chk("rem2_upd_drop", upd_valid, 1'b0);
    chk("tgt2_kept", target[2], 2'd3);

    // Arm timeout on port 0
    beat(7'b0000001, CMD);
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("to_no_err", proto_err, '0);
    end
    tick();
    chk("to_err", proto_err, 7'b0000001);
    tick();
    chk("to_err_clr", proto_err, '0);
    chk("to_no_upd", upd_valid, 1'b0);
    beat(7'b0000001, 64'h0000_0001_0000_0002);
    tick();
    chk("to_idle_data_ignored", upd_valid, 1'b0);

    // Cancel on port 0 before its request is registered
    beat(7'b0000001, CMD);
    beat(7'b0000001, 64'h0000_0001_0000_0002);
    beat(7'b0000001, STOP);
    chk("cancel_no_upd", upd_valid, 1'b0);
    tick();
    chk("cancel_no_upd2", upd_valid, 1'b0);
    chk("cancel_redir", redirect_valid, '0);
    chk("cancel_src_latched", source[0], 2'd2);

    // Reset while an update is held
    upd_ready = 1'b0;
    beat(7'b1000000, CMD);
    beat(7'b1000000, 64'h0000_0001_0000_0002);
    tick();
    chk_upd("held6", 3'd6, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_upd_valid", upd_valid, 1'b0);
    chk("midrst_upd_port", upd_port, 3'd0);
    chk("midrst_upd_tgt", upd_target, 2'd0);
    chk("midrst_source", source, '0);
    chk("midrst_target", target, '0);
    upd_ready = 1'b1;
    tick();
    chk("postrst_upd_valid", upd_valid, 1'b0);

    // Contention on ports 1,4,5 then removal with pointer at 6
    beat(7'b0110010, CMD);
    beat(7'b0110010, 64'h0000_0002_0000_0001);
    tick(); chk_upd("rr_a1", 3'd1, 1'b1);
    tick(); chk_upd("rr_a4", 3'd4, 1'b1);
    tick(); chk_upd("rr_a5", 3'd5, 1'b1);
    tick();
    chk("rr_a_done", upd_valid, 1'b0);
    chk("rr_a_redir", redirect_valid, 7'b0110010);
    beat(7'b0110010, STOP);
    tick(); chk_upd("rr_b1", 3'd1, 1'b0);
    tick(); chk_upd("rr_b4", 3'd4, 1'b0);
    tick(); chk_upd("rr_b5", 3'd5, 1'b0);
    tick();
    chk("rr_b_done", upd_valid, 1'b0);
    chk("rr_b_redir", redirect_valid, '0);

    // Backpressure on port 3
    upd_ready = 1'b0;
    beat(7'b0001000, CMD);
    beat(7'b0001000, 64'h0000_0002_0000_0003);
    tick();
    exp_upd = {1'b1, 3'd3, 1'b1, 2'd3, 2'd2};
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold", {upd_valid, upd_port, upd_install, upd_source, upd_target}, exp_upd);
      tick();
    end
    upd_ready = 1'b1;
    tick();
    chk("bp_hs_drop", upd_valid, 1'b0);
    chk("bp_redir", redirect_valid, 7'b0001000);
    tick();
    chk("bp_no_dup", upd_valid, 1'b0);

    // CMD while ACTIVE is illegal
    beat(7'b0001000, CMD);
    chk("act_cmd_err", proto_err, 7'b0001000);
    chk("act_cmd_redir", redirect_valid, 7'b0001000);
    tick();
    chk("act_cmd_err_clr", proto_err, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
